// File: rtl/bus_rr_arbiter_if.sv
// Purpose: request/grant bundle between the bus masters and the round-robin arbiter.
// Latency: wires only, no state.
// Backpressure: none; masters hold req high until they see their gnt bit.
interface bus_rr_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             bus_busy;
    logic             timeout;

    // master: the requester side; slave: the arbiter side
    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  bus_busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output bus_busy,
        output timeout
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Purpose: round-robin grant of the shared bus, one owner at a time, one turnaround cycle between owners.
// Latency: req sampled in IDLE -> registered gnt one cycle later; optional revoke with BUS_ARB_TIMEOUT_EN.
// Backpressure: owner keeps the bus while its req stays high; other requesters wait, no preemption.
module bus_rr_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_rr_arbiter_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("bus_rr_arbiter: illegal N_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             win_vld;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  ptr_after_owner;
    logic             owner_req;
    logic             expire;

    // Scan requests starting at the priority pointer, wrapping back to 0.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        sel     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sel = ID_W'(idx);
            if (!win_vld && bus.req[sel]) begin
                win_vld = 1'b1;
                win_id  = sel;
            end
        end
    end

    assign owner_req       = bus.req[gnt_id_q];
    assign ptr_after_owner = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // cnt_q counts completed GRANT cycles; the current cycle is the last allowed one at T-1.
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE && win_vld) begin
            cnt_d = '0;
        end else if (state_q == ST_GRANT && cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d  = ST_GRANT;
                    gnt_d    = N_REQ'(1) << win_id;
                    gnt_id_d = win_id;
                    busy_d   = 1'b1;
                end
            end
            ST_GRANT: begin
                // A release on the expiry edge takes precedence, so no timeout pulse then.
                if (!owner_req || expire) begin
                    state_d   = ST_TURN;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = ptr_after_owner;
                    timeout_d = owner_req;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.bus_busy = busy_q;
    assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: vector table, corner sequences and random traffic against a reference model.
// Build with BUS_ARB_TIMEOUT_EN defined to exercise the revoke path (TIMEOUT_CYCLES=4).
module tb_bus_rr_arbiter;
    localparam int N = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int  T     = 4;
    localparam bit  TO_EN = 1'b1;
    localparam int  HOLD  = 2;
`else
    localparam int  T     = 64;
    localparam bit  TO_EN = 1'b0;
    localparam int  HOLD  = 10;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bus_rr_arbiter_if #(.N_REQ(N)) bus ();

    bus_rr_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input logic [N-1:0] m, input string name);
        int k;
        k = 0;
        while (bus.gnt !== m && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(name, bus.gnt, m);
    endtask

    // Reference model: owner index or -1, a one-cycle gap after each release, rotating priority.
    int m_owner, m_last, m_ptr, m_gap, m_held;
    bit m_to;

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_gap = 0; m_held = 0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int best, bestd, d;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 1;
            end else if (TO_EN && m_held == T) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 1; m_to = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap = 0;
        end else if (r != 0) begin
            best = -1; bestd = N;
            for (int i = 0; i < N; i++) begin
                d = (i - m_ptr + N) % N;
                if (r[i] && d < bestd) begin
                    bestd = d; best = i;
                end
            end
            m_owner = best; m_last = best; m_held = 1;
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [1:0]   id;
        logic         busy;
    } vec_t;

    vec_t vt[16];

    initial begin
        int           order[$];
        int           gaps[$];
        int           held, zero_run, pending, o, z, k, cnt;
        bit           onehot_ok, to_ok;
        int           hold_left[N];
        logic [N-1:0] exp_gnt;
        logic [N-1:0] g;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.req  = '0;

        vt[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        vt[2]  = '{4'b0110, 4'b0100, 2'd2, 1'b1};
        vt[3]  = '{4'b1001, 4'b0000, 2'd2, 1'b0};
        vt[4]  = '{4'b1001, 4'b0000, 2'd2, 1'b0};
        vt[5]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        vt[6]  = '{4'b0001, 4'b0000, 2'd3, 1'b0};
        vt[7]  = '{4'b0001, 4'b0000, 2'd3, 1'b0};
        vt[8]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vt[9]  = '{4'b0011, 4'b0001, 2'd0, 1'b1};
        vt[10] = '{4'b0010, 4'b0000, 2'd0, 1'b0};
        vt[11] = '{4'b0010, 4'b0000, 2'd0, 1'b0};
        vt[12] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
        vt[13] = '{4'b0000, 4'b0000, 2'd1, 1'b0};
        vt[14] = '{4'b0000, 4'b0000, 2'd1, 1'b0};
        vt[15] = '{4'b0000, 4'b0000, 2'd1, 1'b0};

        // Reset values, then the vector table
        do_reset();
        chk("reset_gnt", bus.gnt, 0);
        chk("reset_id", bus.gnt_id, 0);
        chk("reset_busy", bus.bus_busy, 0);
        chk("reset_timeout", bus.timeout, 0);
        for (int v = 0; v < 16; v++) begin
            bus.req = vt[v].req;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_gnt", v), bus.gnt, vt[v].gnt);
            chk($sformatf("vec%0d_id", v), bus.gnt_id, vt[v].id);
            chk($sformatf("vec%0d_busy", v), bus.bus_busy, vt[v].busy);
            chk($sformatf("vec%0d_timeout", v), bus.timeout, 0);
            @(negedge clk);
        end

        // Async reset in the middle of a grant
        do_reset();
        bus.req = 4'b0001;
        @(posedge clk);
        #1;
        chk("pre_rst_gnt", bus.gnt, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", bus.gnt, 0);
        chk("async_rst_busy", bus.bus_busy, 0);
        chk("async_rst_id", bus.gnt_id, 0);
        @(negedge clk);
        bus.req = 4'b0100;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_gnt", bus.gnt, 4'b0100);
        chk("post_rst_id", bus.gnt_id, 2);

        // Rotation with all four requesting, each owner holding three cycles
        do_reset();
        bus.req   = 4'b1111;
        held      = 0;
        zero_run  = 0;
        pending   = -1;
        onehot_ok = 1'b1;
        order.delete();
        gaps.delete();
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            @(negedge clk);
            g = bus.gnt;
            if ($countones(g) > 1) onehot_ok = 1'b0;
            if (g != 0) begin
                o = 0;
                for (int i = 0; i < N; i++) if (g[i]) o = i;
                if (held == 0) begin
                    if (order.size() > 0) gaps.push_back(zero_run);
                    order.push_back(o);
                end
                held++;
                zero_run = 0;
                if (held == 3) begin
                    bus.req[o] = 1'b0;
                    held       = 0;
                    pending    = o;
                end
            end else begin
                zero_run++;
                if (pending >= 0) begin
                    bus.req[pending] = 1'b1;
                    pending          = -1;
                end
            end
        end
        chk("rot_count", order.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("rot_order%0d", i), (i < order.size()) ? order[i] : -1, i % 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rot_gap%0d", i), (i < gaps.size()) ? gaps[i] : -1, 2);
        chk("rot_onehot", onehot_ok, 1);

        // No preemption, then lone requester regranted after the turnaround gap
        do_reset();
        bus.req = 4'b0010;
        wait_gnt(4'b0010, "np_first_gnt");
        bus.req = 4'b1111;
        for (int h = 0; h < HOLD; h++) begin
            @(negedge clk);
            chk("np_hold_gnt", bus.gnt, 4'b0010);
        end
        bus.req = 4'b0001;
        z = 0; k = 0;
        do begin
            @(negedge clk);
            if (bus.gnt == 0) z++;
            k++;
        end while (bus.gnt == 0 && k < 10);
        chk("np_gap", z, 2);
        chk("np_next_gnt", bus.gnt, 4'b0001);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("lone_drop_gnt", bus.gnt, 0);
        bus.req = 4'b0001;
        z = 1; k = 0;
        do begin
            @(negedge clk);
            if (bus.gnt == 0) z++;
            k++;
        end while (bus.gnt == 0 && k < 10);
        chk("lone_gap", z, 2);
        chk("lone_regnt", bus.gnt, 4'b0001);

`ifdef BUS_ARB_TIMEOUT_EN
        // Forced revoke after four grant cycles
        do_reset();
        bus.req = 4'b0001;
        wait_gnt(4'b0001, "to_first_gnt");
        cnt = 1; k = 0;
        @(negedge clk);
        while (bus.gnt == 4'b0001 && k < 20) begin
            cnt++; k++;
            @(negedge clk);
        end
        chk("to_hold_cycles", cnt, T);
        chk("to_revoke_gnt", bus.gnt, 0);
        chk("to_pulse", bus.timeout, 1);
        @(negedge clk);
        chk("to_pulse_end", bus.timeout, 0);
        chk("to_gap_gnt", bus.gnt, 0);
        @(negedge clk);
        chk("to_regrant", bus.gnt, 4'b0001);

        // Release on the same edge as expiry
        do_reset();
        bus.req = 4'b0001;
        wait_gnt(4'b0001, "rx_first_gnt");
        repeat (T - 1) @(negedge clk);
        chk("rx_last_cycle_gnt", bus.gnt, 4'b0001);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("rx_gnt", bus.gnt, 0);
        chk("rx_timeout", bus.timeout, 0);
`else
        // Without the revoke feature the grant is unbounded
        do_reset();
        bus.req = 4'b0001;
        wait_gnt(4'b0001, "ub_first_gnt");
        to_ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("ub_hold_gnt", bus.gnt, 4'b0001);
            if (bus.timeout !== 1'b0) to_ok = 1'b0;
        end
        chk("ub_timeout_zero", to_ok, 1);
`endif

        // Random traffic against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < N; i++) hold_left[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_step(bus.req);
            @(negedge clk);
            exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            chk("rnd_gnt", bus.gnt, exp_gnt);
            chk("rnd_id", bus.gnt_id, m_last);
            chk("rnd_busy", bus.bus_busy, (m_owner >= 0) ? 1 : 0);
            chk("rnd_timeout", bus.timeout, m_to);
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(3) == 0) begin
                        bus.req[i]   = 1'b1;
                        hold_left[i] = $urandom_range(6, 1);
                    end
                end else if (bus.gnt[i]) begin
                    hold_left[i]--;
                    if (hold_left[i] <= 0) bus.req[i] = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
